// File: rtl/countdown_timer_fsm_pkg.sv
// countdown_timer_fsm_pkg: state encoding, BCD limits/offsets and preset clamp shared by the timer core
package countdown_timer_fsm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;
  function automatic logic [15:0] clamp_bcd(input logic [15:0] p);
    logic [3:0] mt, mo, st, so;
    mt = p[MIN_TENS_LSB+:4];
    mo = p[MIN_ONES_LSB+:4];
    st = p[SEC_TENS_LSB+:4];
    so = p[SEC_ONES_LSB+:4];
    return {mt > DIGIT_MAX ? DIGIT_MAX : mt, mo > DIGIT_MAX ? DIGIT_MAX : mo,
            st > SEC_TENS_MAX ? SEC_TENS_MAX : st, so > DIGIT_MAX ? DIGIT_MAX : so};
  endfunction
endpackage

// File: rtl/countdown_timer_fsm_if.sv
// countdown_timer_fsm_if: control pulses, preset and display outputs of the timer core
interface countdown_timer_fsm_if;
  import countdown_timer_fsm_pkg::*;
  logic load, start_stop, clear, running, alarm;
  logic [15:0] preset, digits;
  modport master(output load, start_stop, clear, preset, input digits, running, alarm);
  modport slave(input load, start_stop, clear, preset, output digits, running, alarm);
endinterface

// File: rtl/countdown_timer_fsm_tick_sync_edge.sv
// tick_sync_edge: synchronise an async level and emit a 1-cycle pulse on each rising edge
module tick_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic edge_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      edge_q <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      edge_q <= sync[STAGES-1];
    end
  assign pulse = sync[STAGES-1] & ~edge_q;
endmodule

// File: rtl/countdown_timer_fsm.sv
// countdown_timer_fsm: MM:SS BCD kitchen-timer core counting down on synchronised sec_clk edges
module countdown_timer_fsm
  import countdown_timer_fsm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ALARM_TICKS = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sec_clk,
  countdown_timer_fsm_if.slave bus
);
  localparam int AW = ALARM_TICKS > 1 ? $clog2(ALARM_TICKS) : 1;
  state_t state;
  logic [15:0] digits, dec;
  logic [AW-1:0] acnt;
  logic running, alarm, tick, b1, b2, b3;
  tick_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(sec_clk), .pulse(tick));
  always_comb begin
    b1 = digits[3:0] == 4'd0;
    b2 = b1 && digits[7:4] == 4'd0;
    b3 = b2 && digits[11:8] == 4'd0;
    dec[3:0] = b1 ? DIGIT_MAX : digits[3:0] - 4'd1;
    dec[7:4] = b1 ? (digits[7:4] == 4'd0 ? SEC_TENS_MAX : digits[7:4] - 4'd1) : digits[7:4];
    dec[11:8] = b2 ? (digits[11:8] == 4'd0 ? DIGIT_MAX : digits[11:8] - 4'd1) : digits[11:8];
    dec[15:12] = b3 ? (digits[15:12] == 4'd0 ? DIGIT_MAX : digits[15:12] - 4'd1) : digits[15:12];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      digits <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
      acnt <= '0;
    end else if (bus.clear) begin
      state <= IDLE;
      digits <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
      acnt <= '0;
    end else
      case (state)
        IDLE, PAUSE:
          if (bus.load) digits <= clamp_bcd(bus.preset);
          else if (bus.start_stop) begin
            state <= digits != 16'h0 ? RUN : DONE;
            running <= digits != 16'h0;
            alarm <= digits == 16'h0;
            acnt <= '0;
          end
        RUN:
          if (bus.start_stop) begin
            state <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            digits <= dec;
            // reaching 00:00 alarms on the same edge, so a decrement from 00:00 never happens
            if (dec == 16'h0) begin
              state <= DONE;
              running <= 1'b0;
              alarm <= 1'b1;
              acnt <= '0;
            end
          end
        DONE:
          if (bus.load || bus.start_stop) begin
            state <= IDLE;
            alarm <= 1'b0;
            if (bus.load) digits <= clamp_bcd(bus.preset);
          end else if (tick && ALARM_TICKS > 0) begin
            if (int'(acnt) == ALARM_TICKS - 1) begin
              state <= IDLE;
              alarm <= 1'b0;
              acnt <= '0;
            end else acnt <= acnt + 1'b1;
          end
      endcase
  assign bus.digits = digits;
  assign bus.running = running;
  assign bus.alarm = alarm;
endmodule
